// File: rtl/sys_addr_map_unit.sv
// rtl/sys_addr_map_unit.sv - range-rule address decoder with shadow/active tables and staged commit.
// Optional miss log compiled in with `define SYS_ADDR_MAP_ERR_LOG_EN.
module sys_addr_map_unit #(
   parameter int  NUM_RULES   = 6,
   parameter int  NUM_PORTS   = 6,
   parameter int  ADDR_W      = 32,
   parameter int  DEFAULT_IDX = 0,
   localparam int IDX_W       = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1,
   localparam int RULE_W      = (NUM_RULES > 1) ? $clog2(NUM_RULES) : 1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic [ADDR_W-1:0] req_addr_i,
   output logic              rsp_valid_o,
   input  logic              rsp_ready_i,
   output logic [IDX_W-1:0]  rsp_idx_o,
   output logic              rsp_hit_o,
   output logic [ADDR_W-1:0] rsp_addr_o,
   input  logic              cfg_we_i,
   input  logic [RULE_W-1:0] cfg_rule_i,
   input  logic              cfg_en_i,
   input  logic [IDX_W-1:0]  cfg_idx_i,
   input  logic [ADDR_W-1:0] cfg_start_i,
   input  logic [ADDR_W-1:0] cfg_end_i,
   input  logic              commit_i,
   output logic              commit_done_o,
   output logic              err_valid_o,
   output logic [ADDR_W-1:0] err_addr_o,
   output logic [7:0]        err_cnt_o,
   input  logic              err_clr_i
);

   typedef enum logic [1:0] {RUN, DRAIN, COMMIT} state_t;
   state_t state_q, state_d;

   logic              sh_en    [NUM_RULES];
   logic [IDX_W-1:0]  sh_idx   [NUM_RULES];
   logic [ADDR_W-1:0] sh_start [NUM_RULES];
   logic [ADDR_W-1:0] sh_end   [NUM_RULES];
   logic              act_en    [NUM_RULES];
   logic [IDX_W-1:0]  act_idx   [NUM_RULES];
   logic [ADDR_W-1:0] act_start [NUM_RULES];
   logic [ADDR_W-1:0] act_end   [NUM_RULES];

   logic             hit_d;
   logic [IDX_W-1:0] idx_d;
   logic             accept;
   logic             cfg_ok;

   assign req_ready_o = (state_q == RUN) && (!rsp_valid_o || rsp_ready_i);
   assign accept      = req_valid_i && req_ready_o;
   assign cfg_ok      = cfg_we_i && (int'(cfg_rule_i) < NUM_RULES);

   // Scan high-to-low so the lowest-numbered matching rule is the one left standing.
   always_comb begin
      hit_d = 1'b0;
      idx_d = IDX_W'(DEFAULT_IDX);
      for (int r = NUM_RULES - 1; r >= 0; r--) begin
         if (act_en[r] && (req_addr_i >= act_start[r]) &&
             ((act_end[r] == '0) || (req_addr_i < act_end[r]))) begin
            hit_d = 1'b1;
            idx_d = act_idx[r];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         RUN:     if (commit_i) state_d = DRAIN;
         DRAIN:   if (!rsp_valid_o || rsp_ready_i) state_d = COMMIT;
         COMMIT:  state_d = RUN;
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q       <= RUN;
         commit_done_o <= 1'b0;
      end else begin
         state_q       <= state_d;
         commit_done_o <= (state_q == COMMIT);
      end
   end

   // Active copy reads shadow's pre-edge contents, so a same-cycle cfg write only reaches shadow.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int r = 0; r < NUM_RULES; r++) begin
            sh_en[r]     <= 1'b0;
            sh_idx[r]    <= '0;
            sh_start[r]  <= '0;
            sh_end[r]    <= '0;
            act_en[r]    <= 1'b0;
            act_idx[r]   <= '0;
            act_start[r] <= '0;
            act_end[r]   <= '0;
         end
      end else begin
         if (state_q == COMMIT) begin
            for (int r = 0; r < NUM_RULES; r++) begin
               act_en[r]    <= sh_en[r];
               act_idx[r]   <= sh_idx[r];
               act_start[r] <= sh_start[r];
               act_end[r]   <= sh_end[r];
            end
         end
         if (cfg_ok) begin
            sh_en[cfg_rule_i]    <= cfg_en_i;
            sh_idx[cfg_rule_i]   <= cfg_idx_i;
            sh_start[cfg_rule_i] <= cfg_start_i;
            sh_end[cfg_rule_i]   <= cfg_end_i;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rsp_valid_o <= 1'b0;
         rsp_idx_o   <= '0;
         rsp_hit_o   <= 1'b0;
         rsp_addr_o  <= '0;
      end else if (accept) begin
         rsp_valid_o <= 1'b1;
         rsp_idx_o   <= idx_d;
         rsp_hit_o   <= hit_d;
         rsp_addr_o  <= req_addr_i;
      end else if (rsp_ready_i) begin
         rsp_valid_o <= 1'b0;
      end
   end

`ifdef SYS_ADDR_MAP_ERR_LOG_EN
   logic miss_acc;
   assign miss_acc = accept && !hit_d;

   // A miss arriving with a clear starts a fresh log rather than being lost.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         err_valid_o <= 1'b0;
         err_addr_o  <= '0;
         err_cnt_o   <= '0;
      end else if (err_clr_i) begin
         err_valid_o <= miss_acc;
         err_cnt_o   <= miss_acc ? 8'd1 : 8'd0;
         if (miss_acc) err_addr_o <= req_addr_i;
      end else if (miss_acc) begin
         if (err_cnt_o != 8'hFF) err_cnt_o <= err_cnt_o + 8'd1;
         if (!err_valid_o) begin
            err_valid_o <= 1'b1;
            err_addr_o  <= req_addr_i;
         end
      end
   end
`else
   logic unused_err_clr;
   assign unused_err_clr = err_clr_i;
   assign err_valid_o    = 1'b0;
   assign err_addr_o     = '0;
   assign err_cnt_o      = '0;
`endif

endmodule

// File: tb/tb_sys_addr_map_unit.sv
// tb/tb_sys_addr_map_unit.sv - directed plus randomized bench for sys_addr_map_unit against a rule-list model.
module tb_sys_addr_map_unit;

`ifdef SYS_ADDR_MAP_ERR_LOG_EN
   localparam bit LOG = 1'b1;
`else
   localparam bit LOG = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_valid = 1'b0, req_ready;
   logic [31:0] req_addr = '0;
   logic        rsp_valid, rsp_ready = 1'b1, rsp_hit;
   logic [2:0]  rsp_idx;
   logic [31:0] rsp_addr;
   logic        cfg_we = 1'b0, cfg_en = 1'b0;
   logic [2:0]  cfg_rule = '0, cfg_idx = '0;
   logic [31:0] cfg_start = '0, cfg_end = '0;
   logic        commit = 1'b0, commit_done;
   logic        err_valid, err_clr = 1'b0;
   logic [31:0] err_addr;
   logic [7:0]  err_cnt;

   int n_cmp = 0;
   int n_mis = 0;

   typedef struct { bit en; logic [2:0] idx; logic [31:0] s; logic [31:0] e; } rule_t;
   rule_t sh[6];
   rule_t act[6];
   bit          m_ev;
   logic [31:0] m_ea;
   int          m_ec;

   sys_addr_map_unit dut (
      .clk_i(clk), .rst_i(rst),
      .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
      .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_idx_o(rsp_idx),
      .rsp_hit_o(rsp_hit), .rsp_addr_o(rsp_addr),
      .cfg_we_i(cfg_we), .cfg_rule_i(cfg_rule), .cfg_en_i(cfg_en), .cfg_idx_i(cfg_idx),
      .cfg_start_i(cfg_start), .cfg_end_i(cfg_end),
      .commit_i(commit), .commit_done_o(commit_done),
      .err_valid_o(err_valid), .err_addr_o(err_addr), .err_cnt_o(err_cnt), .err_clr_i(err_clr)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // First rule (in number order) whose half-open range contains the address wins.
   task automatic model_decode(input logic [31:0] a, output logic [2:0] idx, output bit hit);
      longint unsigned hi;
      hit = 1'b0;
      idx = 3'd0;
      for (int r = 0; r < 6; r++) begin
         hi = (act[r].e == 0) ? 64'h1_0000_0000 : {32'd0, act[r].e};
         if (!hit && act[r].en && {32'd0, a} >= {32'd0, act[r].s} && {32'd0, a} < hi) begin
            hit = 1'b1;
            idx = act[r].idx;
         end
      end
   endtask

   task automatic model_err(input bit hit, input bit clr, input logic [31:0] a);
      if (clr) begin
         m_ev = !hit;
         m_ec = hit ? 0 : 1;
         if (!hit) m_ea = a;
      end else if (!hit) begin
         if (m_ec < 255) m_ec++;
         if (!m_ev) begin
            m_ev = 1'b1;
            m_ea = a;
         end
      end
   endtask

   task automatic chk_err();
      chk("err_valid", err_valid, LOG ? m_ev : 1'b0);
      chk("err_addr", err_addr, LOG ? m_ea : 32'd0);
      chk("err_cnt", err_cnt, LOG ? m_ec : 0);
   endtask

   task automatic cfg(input logic [2:0] r, input bit en, input logic [2:0] idx,
                      input logic [31:0] s, input logic [31:0] e);
      cfg_rule = r; cfg_en = en; cfg_idx = idx; cfg_start = s; cfg_end = e; cfg_we = 1'b1;
      tick();
      cfg_we = 1'b0;
      if (r < 6) sh[r] = '{en, idx, s, e};
   endtask

   task automatic clear_log();
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      m_ev = 1'b0;
      m_ec = 0;
      chk_err();
   endtask

   // want: -1 for model-only, else {hit,idx[2:0]} fixed by the directed scenario.
   task automatic send(input logic [31:0] a, input int stall, input bit clr, input int want);
      logic [2:0] ei;
      bit eh;
      req_addr = a; req_valid = 1'b1; rsp_ready = (stall == 0); err_clr = clr;
      chk("req_ready_idle", req_ready, 1'b1);
      model_decode(a, ei, eh);
      model_err(eh, clr, a);
      tick();
      req_valid = 1'b0; err_clr = 1'b0;
      chk_err();
      if (want >= 0) begin
         chk("spec_idx", rsp_idx, want & 7);
         chk("spec_hit", rsp_hit, (want >> 3) & 1);
      end
      for (int s = 0; s <= stall; s++) begin
         chk("rsp_valid", rsp_valid, 1'b1);
         chk("rsp_idx", rsp_idx, ei);
         chk("rsp_hit", rsp_hit, eh);
         chk("rsp_addr", rsp_addr, a);
         if (s < stall) begin
            chk("req_ready_stall", req_ready, 1'b0);
            tick();
         end
      end
      rsp_ready = 1'b1;
      tick();
      chk("rsp_popped", rsp_valid, 1'b0);
   endtask

   function automatic logic [31:0] pick_addr();
      int r = $urandom_range(0, 5);
      case ($urandom_range(0, 4))
         0:       return act[r].s;
         1:       return act[r].e - 32'd1;
         2:       return act[r].e;
         3:       return act[r].s - 32'd4;
         default: return $urandom;
      endcase
   endfunction

   // Back-to-back accepts: a new request every cycle while rsp_ready stays high.
   task automatic burst(input int n, input bit rnd, input logic [31:0] base);
      logic [31:0] a;
      logic [2:0] ei;
      bit eh;
      rsp_ready = 1'b1;
      for (int k = 0; k < n; k++) begin
         a = rnd ? pick_addr() : base + 32'(k * 4);
         req_addr = a; req_valid = 1'b1;
         chk("burst_ready", req_ready, 1'b1);
         model_decode(a, ei, eh);
         model_err(eh, 1'b0, a);
         tick();
         chk("burst_valid", rsp_valid, 1'b1);
         chk("burst_idx", rsp_idx, ei);
         chk("burst_hit", rsp_hit, eh);
         chk("burst_addr", rsp_addr, a);
      end
      req_valid = 1'b0;
      tick();
      chk("burst_drained", rsp_valid, 1'b0);
      chk_err();
   endtask

   task automatic do_commit();
      int pulses = 0;
      int at = -1;
      commit = 1'b1;
      tick();
      commit = 1'b0;
      for (int k = 0; k < 6; k++) begin
         tick();
         if (commit_done) begin
            pulses++;
            if (at < 0) at = k;
         end
      end
      chk("commit_pulses", pulses, 1);
      chk("commit_pulse_pos", at, 1);
      act = sh;
   endtask

   task automatic reset_model();
      for (int r = 0; r < 6; r++) begin
         sh[r]  = '{1'b0, 3'd0, 32'd0, 32'd0};
         act[r] = '{1'b0, 3'd0, 32'd0, 32'd0};
      end
      m_ev = 1'b0; m_ea = '0; m_ec = 0;
   endtask

   initial begin
      logic [31:0] a;
      logic [2:0]  ei;
      bit          eh;
      int          pulses;

      reset_model();
      #1 rst = 1'b1;
      #1;
      chk("rst_rsp_valid", rsp_valid, 1'b0);
      chk("rst_rsp_idx", rsp_idx, 3'd0);
      chk("rst_rsp_hit", rsp_hit, 1'b0);
      chk("rst_rsp_addr", rsp_addr, 32'd0);
      chk("rst_commit_done", commit_done, 1'b0);
      chk_err();
      tick();
      tick();
      rst = 1'b0;
      chk("ready_after_rst", req_ready, 1'b1);

      send(32'hF002_0000, 0, 1'b0, 0);

      cfg(0, 1'b1, 3'd3, 32'hF002_0000, 32'hF002_8000);
      send(32'hF002_7FFC, 0, 1'b0, 0);
      do_commit();
      send(32'hF002_7FFC, 0, 1'b0, 8 | 3);
      send(32'hF002_8000, 1, 1'b0, 0);
      send(32'hF002_0000, 0, 1'b0, 8 | 3);

      cfg(0, 1'b1, 3'd1, 32'hF001_0000, 32'hF001_2000);
      cfg(1, 1'b1, 3'd2, 32'h0000_0000, 32'h4100_0000);
      cfg(2, 1'b1, 3'd5, 32'hF000_0000, 32'h0000_0000);
      cfg(7, 1'b1, 3'd7, 32'h4100_0000, 32'h0000_0000);
      do_commit();
      send(32'hF001_1000, 0, 1'b0, 8 | 1);
      send(32'hFFFF_FFFC, 2, 1'b0, 8 | 5);
      send(32'h40FF_FFFC, 0, 1'b0, 8 | 2);

      clear_log();
      send(32'h4100_0000, 0, 1'b0, 0);
      send(32'h5000_0000, 0, 1'b0, 0);
      send(32'h6000_0000, 0, 1'b0, 0);
`ifdef SYS_ADDR_MAP_ERR_LOG_EN
      chk("log3_addr", err_addr, 32'h4100_0000);
      chk("log3_cnt", err_cnt, 8'd3);
`endif
      send(32'h7000_0000, 0, 1'b1, 0);
`ifdef SYS_ADDR_MAP_ERR_LOG_EN
      chk("logclr_addr", err_addr, 32'h7000_0000);
      chk("logclr_cnt", err_cnt, 8'd1);
`endif
      clear_log();
      burst(258, 1'b0, 32'h5000_0000);
`ifdef SYS_ADDR_MAP_ERR_LOG_EN
      chk("log_saturated", err_cnt, 8'd255);
`endif

      // Commit while a response is held: drain, then copy, with a same-cycle shadow write.
      cfg(3, 1'b1, 3'd4, 32'h6000_0000, 32'h6000_1000);
      a = 32'h6000_0010;
      rsp_ready = 1'b0; req_addr = a; req_valid = 1'b1;
      model_decode(a, ei, eh);
      model_err(eh, 1'b0, a);
      tick();
      req_valid = 1'b0;
      commit = 1'b1;
      tick();
      commit = 1'b0;
      for (int k = 0; k < 4; k++) begin
         chk("drain_ready", req_ready, 1'b0);
         chk("drain_valid", rsp_valid, 1'b1);
         chk("drain_hit", rsp_hit, eh);
         chk("drain_addr", rsp_addr, a);
         chk("drain_done", commit_done, 1'b0);
         commit = (k == 1);
         tick();
      end
      commit = 1'b0;
      rsp_ready = 1'b1;
      tick();
      chk("commit_state_valid", rsp_valid, 1'b0);
      chk("commit_state_ready", req_ready, 1'b0);
      chk("commit_state_done", commit_done, 1'b0);
      cfg_rule = 3'd4; cfg_en = 1'b1; cfg_idx = 3'd6;
      cfg_start = 32'h6100_0000; cfg_end = 32'h6100_0100; cfg_we = 1'b1;
      commit = 1'b1;
      act = sh;
      sh[4] = '{1'b1, 3'd6, 32'h6100_0000, 32'h6100_0100};
      tick();
      cfg_we = 1'b0; commit = 1'b0;
      chk("post_commit_done", commit_done, 1'b1);
      chk("post_commit_ready", req_ready, 1'b1);
      pulses = 0;
      for (int k = 0; k < 4; k++) begin
         tick();
         pulses += int'(commit_done);
      end
      chk("no_extra_commit", pulses, 0);
      send(32'h6000_0010, 0, 1'b0, 8 | 4);
      send(32'h6100_0010, 0, 1'b0, 0);
      do_commit();
      send(32'h6100_0010, 0, 1'b0, 8 | 6);

      for (int it = 0; it < 60; it++) begin
         case ($urandom_range(0, 4))
            0, 1: begin
               logic [31:0] s;
               logic [31:0] e;
               s = $urandom & 32'hFFFF_F000;
               case ($urandom_range(0, 3))
                  0:       e = 32'd0;
                  1:       e = s - 32'h10;
                  2:       e = s;
                  default: e = s + 32'($urandom_range(1, 64) << 8);
               endcase
               cfg(3'($urandom_range(0, 7)), 1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 5)), s, e);
            end
            2: do_commit();
            3: send(pick_addr(), $urandom_range(0, 2), 1'($urandom_range(0, 7) == 0), -1);
            default: burst($urandom_range(2, 6), 1'b1, 32'd0);
         endcase
      end

      // Asynchronous reset in the middle of a drain.
      do_commit();
      rsp_ready = 1'b0; req_addr = 32'hF001_1000; req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      commit = 1'b1;
      tick();
      commit = 1'b0;
      tick();
      #2 rst = 1'b1;
      #1;
      reset_model();
      chk("mid_rst_valid", rsp_valid, 1'b0);
      chk("mid_rst_idx", rsp_idx, 3'd0);
      chk("mid_rst_hit", rsp_hit, 1'b0);
      chk("mid_rst_addr", rsp_addr, 32'd0);
      chk("mid_rst_done", commit_done, 1'b0);
      chk("mid_rst_err_valid", err_valid, 1'b0);
      chk("mid_rst_err_cnt", err_cnt, 8'd0);
      chk("mid_rst_err_addr", err_addr, 32'd0);
      tick();
      rst = 1'b0;
      rsp_ready = 1'b1;
      pulses = 0;
      for (int k = 0; k < 4; k++) begin
         pulses += int'(commit_done);
         tick();
      end
      chk("abandoned_commit", pulses, 0);
      send(32'hF001_1000, 0, 1'b0, 0);
      send(32'hF002_0000, 0, 1'b0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/sys_addr_map_unit.md
SYS_ADDR_MAP_UNIT -- requirements
Module: sys_addr_map_unit

Interface
REQ-001 SHALL have parameter NUM_RULES, default 6: number of address rules (1..16).
REQ-002 SHALL have parameter NUM_PORTS, default 6: number of target ports; IDX_W = max(1, clog2(NUM_PORTS)).
REQ-003 SHALL have parameter ADDR_W, default 32: address width.
REQ-004 SHALL have parameter DEFAULT_IDX, default 0: port returned on a miss (error slave).
REQ-005 SHALL have port clk_i  in  1: single clock, rising edge.
REQ-006 SHALL have port rst_i  in  1: reset, asynchronous and active-high.
REQ-007 SHALL have ports req_valid_i in 1, req_ready_o out 1, req_addr_i in ADDR_W: decode request handshake.
REQ-008 SHALL have ports rsp_valid_o out 1, rsp_ready_i in 1, rsp_idx_o out IDX_W, rsp_hit_o out 1, rsp_addr_o out ADDR_W: decode result handshake.
REQ-009 SHALL have ports cfg_we_i in 1, cfg_rule_i in clog2(NUM_RULES), cfg_en_i in 1, cfg_idx_i in IDX_W, cfg_start_i in ADDR_W, cfg_end_i in ADDR_W: shadow rule write.
REQ-010 SHALL have ports commit_i in 1, commit_done_o out 1: shadow-to-active table commit.
REQ-011 SHALL have ports err_valid_o out 1, err_addr_o out ADDR_W, err_cnt_o out 8, err_clr_i in 1: miss log.

Function
REQ-012 SHALL hold two rule tables (shadow, active); each rule = {en, idx, start, end}; decode uses active only.
REQ-013 SHALL match rule r when en=1 and start <= addr < end; end=0 SHALL mean upper bound 2^ADDR_W; end <= start with end != 0 SHALL never match.
REQ-014 SHALL resolve overlapping matches to the lowest rule number.
REQ-015 SHALL return DEFAULT_IDX with rsp_hit_o=0 on a miss; hit returns rule idx with rsp_hit_o=1.
REQ-016 SHALL register the result: request accepted in cycle N appears on rsp_* in cycle N+1 (latency 1), rsp_addr_o echoing the address.
REQ-017 SHALL drive req_ready_o = (state==RUN) and (!rsp_valid_o or rsp_ready_i); full-throughput back-to-back accepts.
REQ-018 SHALL hold rsp_* stable while rsp_valid_o=1 and rsp_ready_i=0.
REQ-019 SHALL write cfg_* into shadow rule cfg_rule_i on cfg_we_i in any state; cfg_rule_i >= NUM_RULES SHALL be ignored.
REQ-020 SHALL implement FSM RUN -> DRAIN on commit_i; DRAIN -> COMMIT when rsp_valid_o=0 (or popped that cycle); COMMIT -> RUN after one cycle.
REQ-021 SHALL copy shadow to active in COMMIT using shadow contents before any same-cycle cfg write; the write still lands in shadow.
REQ-022 SHALL pulse commit_done_o for exactly one cycle, the cycle after COMMIT; commit_i outside RUN SHALL be ignored.

Reset
REQ-023 SHALL on rst_i clear all rules in both tables (en=0, fields 0), state=RUN, rsp_valid_o=0, rsp_idx_o=0, rsp_hit_o=0, rsp_addr_o=0, commit_done_o=0, err_valid_o=0, err_addr_o=0, err_cnt_o=0.
REQ-024 SHALL abandon any in-progress DRAIN/COMMIT on reset; active table stays cleared.

Configuration
REQ-025 SHALL compile the miss log only when macro SYS_ADDR_MAP_ERR_LOG_EN is defined.
REQ-026 With the macro: on each accepted miss SHALL increment err_cnt_o saturating at 255; first miss while err_valid_o=0 SHALL capture err_addr_o and set err_valid_o.
REQ-027 With the macro: err_clr_i SHALL clear err_valid_o and err_cnt_o; a simultaneous miss SHALL win (err_valid_o=1, new address, err_cnt_o=1).
REQ-028 Without the macro: err_valid_o, err_addr_o, err_cnt_o SHALL be constant 0 and err_clr_i ignored.

Verification
REQ-029 After reset, request 0xF0020000 -> rsp next cycle idx=0, hit=0 (all rules disabled).
REQ-030 Shadow rule0 {1,3,0xF0020000,0xF0028000}, commit, request 0xF0027FFC -> idx=3 hit=1; 0xF0028000 -> miss; commit_done_o one pulse.
REQ-031 Rule0 {1,1,0xF0010000,0xF0012000}, rule1 {1,2,0x0,0x41000000}, rule2 {1,5,0xF0000000,0x0}; 0xF0011000 -> 1, 0xFFFFFFFC -> 5 (end=0 wrap), 0x40FFFFFC -> 2.
REQ-032 rsp_ready_i=0 with rsp pending, commit_i pulsed -> req_ready_o=0, state holds DRAIN until pop, then COMMIT, commit_done_o, accepts resume.
REQ-033 (macro on) three misses 0x41000000, 0x50000000, 0x60000000 -> err_addr_o=0x41000000, err_cnt_o=3; err_clr_i with 4th miss 0x70000000 -> err_addr_o=0x70000000, err_cnt_o=1.
REQ-034 rst_i asserted mid-DRAIN -> all outputs per REQ-023 asynchronously, next request after release decodes as miss.
